pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath payload width (PC+2, read data, immediate).
REQ-002 SHALL have parameter CTRL_W, default 10, control-bundle width (RegDst, ALUSrc, ALUOp, MemRead, MemWrite, Branch, MemtoReg, RegWrite, spare).
REQ-003 SHALL have parameter CNT_W, default 16, occupancy/hold counter width.
REQ-004 SHALL use one clock; reset synchronous, active-low: clk input 1 rising-edge clock; rst_n input 1 sync active-low reset.
REQ-005 in_valid input 1; upstream beat valid.
REQ-006 in_ready output 1; stage accepts beat this cycle.
REQ-007 in_data input DATA_W; in_ctrl input CTRL_W.
REQ-008 stall input 1; hazard stall, blocks acceptance.
REQ-009 flush input 1; branch-taken flush, kills held beats.
REQ-010 out_valid output 1; out_ready input 1; out_data output DATA_W; out_ctrl output CTRL_W.
REQ-011 hold_cnt output CNT_W; saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-012 Accept = in_valid & in_ready; drain = out_valid & out_ready; evaluated at rising clk.
REQ-013 Latency: accepted beat appears on out_* next cycle; order preserved, no duplication, no loss (except flush).
REQ-014 States: EMPTY (out_valid=0), FULL (main entry valid); SKID only per REQ-024.
REQ-015 EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on accept+drain (main reloaded) or neither.
REQ-016 stall=1: in_ready=0; held beat still presented and drainable.
REQ-017 flush=1: in_ready=0, next state EMPTY, out_ctrl driven to BUBBLE_CTRL (all zero) next cycle; flush overrides accept, drain and stall.
REQ-018 out_ctrl SHALL equal BUBBLE_CTRL whenever out_valid=0; out_data holds last value (don't-care).
REQ-019 hold_cnt increments by 1 per cycle with out_valid & !out_ready, saturates at all-ones, never wraps; unaffected by flush.

Reset
REQ-020 rst_n=0 at rising clk: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, hold_cnt=0, skid entry invalid.
REQ-021 in_ready SHALL be 0 during reset cycle and 1 first cycle after (stall=flush=0).
REQ-022 Reset mid-transfer discards all held beats; reset dominates flush and stall.

Configuration
REQ-023 Without PIPE_SKID_EN: single entry; in_ready = !stall & !flush & (!out_valid | out_ready) (combinational from out_ready).
REQ-024 With PIPE_SKID_EN: two entries (main, skid); in_ready = rdy_q & !stall & !flush, rdy_q a flop, no combinational out_ready->in_ready path; FULL->SKID on accept without drain; SKID->FULL on drain (skid moves to main); rdy_q=0 only in SKID; flush from SKID -> EMPTY.

Structure
REQ-025 Shared package pipe_pkg: state enum {ST_EMPTY, ST_FULL, ST_SKID}, BUBBLE_CTRL constant, default DATA_W/CTRL_W/CNT_W constants.
REQ-026 hold_cnt SHALL be one sub-module sat_counter (parametrised width, inc, sync clear).
REQ-027 Instances replace IF_ID and ID_EX registers in the pipeline top; one module serves both.

Verification
REQ-028 Pass-through: out_ready=1, beats data 0x0002,0x0004,0x0006 ctrl 0x3FF on consecutive cycles -> same values on out_* one cycle later, out_valid continuous.
REQ-029 Backpressure: hold out_ready=0 5 cycles with beat 0xBEEF -> out_data stays 0xBEEF, hold_cnt=5; skid build: second beat 0xCAFE accepted, in_ready=0 next cycle, both drain in order after release.
REQ-030 Flush: FULL with ctrl 0x3FF, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, incoming beat dropped.
REQ-031 Stall: stall=1 3 cycles, in_valid=1 -> in_ready=0, no accept; held beat drains normally.
REQ-032 Saturation: CNT_W=4, out_ready=0 20 cycles -> hold_cnt stops at 0xF.
REQ-033 Reset mid-SKID: rst_n=0 one cycle -> out_valid=0, out_ctrl=0, hold_cnt=0, in_ready=1 following cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage register and its users.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_CTRL_W = 10;
  localparam int unsigned DEF_CNT_W  = 16;

  // Control bundle of a squashed/empty slot: every control bit deasserted.
  localparam logic [DEF_CTRL_W-1:0] BUBBLE_CTRL = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready bus of one pipeline stage register.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  // Environment side: feeds beats in and consumes beats out.
  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones, never wraps.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register (IF/ID, ID/EX) with stall, flush and hold counter.
// Define PIPE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(BUBBLE_CTRL);

  state_e            state_q, state_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic              in_ready_c, accept_c, drain_c, load_main_c, hold_inc_c;
`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic              rdy_q, load_skid_c, promote_c;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic; flush squashes everything held
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept_c) state_d = ST_FULL;
        ST_FULL: begin
          if (drain_c && !accept_c) state_d = ST_EMPTY;
`ifdef PIPE_SKID_EN
          else if (accept_c && !drain_c) state_d = ST_SKID;
`endif
        end
`ifdef PIPE_SKID_EN
        ST_SKID:  if (drain_c) state_d = ST_FULL;
`else
        ST_SKID:  state_d = ST_EMPTY;
`endif
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake and datapath steering
  always_comb begin
`ifdef PIPE_SKID_EN
    in_ready_c  = rst_n & rdy_q & !stall & !flush;
`else
    in_ready_c  = rst_n & !stall & !flush & (!out_valid_q | bus.out_ready);
`endif
    accept_c    = bus.in_valid & in_ready_c;
    drain_c     = out_valid_q & bus.out_ready;
    load_main_c = accept_c & ((state_q == ST_EMPTY) | drain_c);
    hold_inc_c  = out_valid_q & !bus.out_ready;
`ifdef PIPE_SKID_EN
    load_skid_c = accept_c & (state_q == ST_FULL) & !drain_c;
    promote_c   = drain_c & (state_q == ST_SKID);
`endif
  end

  // Main entry; control collapses to a bubble whenever the stage goes empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= BUBBLE;
    end else begin
      out_valid_q <= (state_d != ST_EMPTY);
      if (state_d == ST_EMPTY) begin
        main_ctrl_q <= BUBBLE;
      end else if (load_main_c) begin
        main_data_q <= bus.in_data;
        main_ctrl_q <= bus.in_ctrl;
      end
`ifdef PIPE_SKID_EN
      else if (promote_c) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
`endif
    end
  end

`ifdef PIPE_SKID_EN
  // Skid entry and registered ready, low only while the skid slot is occupied
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_data_q <= '0;
      skid_ctrl_q <= BUBBLE;
      rdy_q       <= 1'b1;
    end else begin
      rdy_q <= (state_d != ST_SKID);
      if (load_skid_c) begin
        skid_data_q <= bus.in_data;
        skid_ctrl_q <= bus.in_ctrl;
      end
    end
  end
`endif

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .clr (!rst_n),
    .inc (hold_inc_c),
    .cnt (hold_cnt)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (either build of PIPE_SKID_EN).
module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] hold_cnt;
  logic [3:0]  sat_cnt;
  int          n_chk  = 0;
  int          n_pass = 0;

  pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(10)) bus ();
  pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(10)) sbus ();

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(10), .CNT_W(16)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .flush    (flush),
    .bus      (bus),
    .hold_cnt (hold_cnt)
  );

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(10), .CNT_W(4)) u_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (1'b0),
    .flush    (1'b0),
    .bus      (sbus),
    .hold_cnt (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs at the falling edge; outputs are checked 1 ns later.
  task automatic drive(input logic v, input logic [15:0] d, input logic [9:0] c,
                       input logic ordy, input logic stl, input logic fl);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    stall         = stl;
    flush         = fl;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    sbus.in_valid  = 1'b0;
    sbus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_ctrl",  32'(bus.out_ctrl),  32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_hold_cnt",  32'(hold_cnt),      32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_ctrl    = '0;
    bus.out_ready  = 1'b0;
    sbus.in_valid  = 1'b0;
    sbus.in_data   = '0;
    sbus.in_ctrl   = '0;
    sbus.out_ready = 1'b1;

    // Pass-through with continuous out_ready
    do_reset();
    drive(1'b1, 16'h0002, 10'h3FF, 1'b1, 1'b0, 1'b0);
    chk("pt_empty_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 16'h0004, 10'h3FF, 1'b1, 1'b0, 1'b0);
    chk("pt_b0_valid", 32'(bus.out_valid), 32'd1);
    chk("pt_b0_data",  32'(bus.out_data),  32'h0002);
    chk("pt_b0_ctrl",  32'(bus.out_ctrl),  32'h3FF);
    chk("pt_in_ready", 32'(bus.in_ready),  32'd1);
    drive(1'b1, 16'h0006, 10'h3FF, 1'b1, 1'b0, 1'b0);
    chk("pt_b1_valid", 32'(bus.out_valid), 32'd1);
    chk("pt_b1_data",  32'(bus.out_data),  32'h0004);
    drive(1'b0, 16'h0000, 10'h000, 1'b1, 1'b0, 1'b0);
    chk("pt_b2_valid", 32'(bus.out_valid), 32'd1);
    chk("pt_b2_data",  32'(bus.out_data),  32'h0006);
    drive(1'b0, 16'h0000, 10'h000, 1'b1, 1'b0, 1'b0);
    chk("pt_drained_valid", 32'(bus.out_valid), 32'd0);
    chk("pt_drained_ctrl",  32'(bus.out_ctrl),  32'd0);
    chk("pt_hold_cnt",      32'(hold_cnt),      32'd0);

    // Backpressure: BEEF held five cycles while CAFE waits (or skids)
    do_reset();
    drive(1'b1, 16'hBEEF, 10'h155, 1'b0, 1'b0, 1'b0);
    chk("bp_accept_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 16'hCAFE, 10'h0AA, 1'b0, 1'b0, 1'b0);
      chk("bp_hold_data", 32'(bus.out_data), 32'hBEEF);
      chk("bp_hold_cnt",  32'(hold_cnt),     32'(i - 1));
      if (i == 1) chk("bp_first_ready", 32'(bus.in_ready), 32'(SKID));
      else        chk("bp_later_ready", 32'(bus.in_ready), 32'd0);
    end
    drive(!SKID, 16'hCAFE, 10'h0AA, 1'b1, 1'b0, 1'b0);
    chk("bp_rel_data",  32'(bus.out_data), 32'hBEEF);
    chk("bp_rel_cnt",   32'(hold_cnt),     32'd5);
    chk("bp_rel_ready", 32'(bus.in_ready), 32'(!SKID));
    drive(1'b0, 16'h0000, 10'h000, 1'b1, 1'b0, 1'b0);
    chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_second_data",  32'(bus.out_data),  32'hCAFE);
    chk("bp_second_ctrl",  32'(bus.out_ctrl),  32'h0AA);
    drive(1'b0, 16'h0000, 10'h000, 1'b0, 1'b0, 1'b0);
    chk("bp_done_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_done_ctrl",  32'(bus.out_ctrl),  32'd0);
    chk("bp_done_cnt",   32'(hold_cnt),      32'd5);

    // Flush kills the held beat and drops the incoming one
    do_reset();
    drive(1'b1, 16'h1234, 10'h3FF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h5555, 10'h111, 1'b0, 1'b0, 1'b1);
    chk("fl_full_valid", 32'(bus.out_valid), 32'd1);
    chk("fl_full_ctrl",  32'(bus.out_ctrl),  32'h3FF);
    chk("fl_in_ready",   32'(bus.in_ready),  32'd0);
    drive(1'b0, 16'h0000, 10'h000, 1'b0, 1'b0, 1'b0);
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_ctrl",  32'(bus.out_ctrl),  32'd0);
    chk("fl_data",  32'(bus.out_data),  32'h1234);
    chk("fl_cnt",   32'(hold_cnt),      32'd1);

    // Stall blocks acceptance but the held beat still drains
    do_reset();
    drive(1'b1, 16'h00A1, 10'h0F0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h00B2, 10'h00F, 1'b1, 1'b1, 1'b0);
      chk("st_in_ready", 32'(bus.in_ready), 32'd0);
      if (i == 0) begin
        chk("st_held_valid", 32'(bus.out_valid), 32'd1);
        chk("st_held_data",  32'(bus.out_data),  32'h00A1);
      end else begin
        chk("st_drained_valid", 32'(bus.out_valid), 32'd0);
        chk("st_drained_ctrl",  32'(bus.out_ctrl),  32'd0);
      end
    end
    drive(1'b0, 16'h0000, 10'h000, 1'b1, 1'b0, 1'b0);
    chk("st_no_accept", 32'(bus.out_valid), 32'd0);
    chk("st_ready_back", 32'(bus.in_ready), 32'd1);

    // Hold counter saturation on the 4-bit instance
    do_reset();
    @(negedge clk);
    sbus.in_valid  = 1'b1;
    sbus.in_data   = 16'h0077;
    sbus.in_ctrl   = 10'h3FF;
    sbus.out_ready = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      sbus.in_valid = 1'b0;
      #1;
      if (i == 15) chk("sat_below", 32'(sat_cnt), 32'hE);
    end
    chk("sat_top",  32'(sat_cnt),       32'hF);
    chk("sat_data", 32'(sbus.out_data), 32'h0077);

    // Reset while both entries may be occupied
    drive(1'b1, 16'h1111, 10'h0C3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h2222, 10'h03C, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h3333, 10'h3C0, 1'b0, 1'b0, 1'b0);
    chk("mr_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("mr_pre_cnt",   32'(hold_cnt),      32'd1);
    do_reset();
    chk("mr_sat_cnt", 32'(sat_cnt), 32'd0);
    drive(1'b0, 16'h0000, 10'h000, 1'b1, 1'b0, 1'b0);
    chk("mr_post_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_post_ctrl",  32'(bus.out_ctrl),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
